// File: rtl/ber_checker_if.sv
// ber_checker_if: sample stream in, decisions and BER statistics out.
interface ber_checker_if #(
  parameter int NB_INPUT = 8,
  parameter int NB_DLY   = 5,
  parameter int NB_CNT   = 32
);
  logic signed [NB_INPUT-1:0] i_os_data;
  logic                       i_valid;
  logic                       i_enb;
  logic [1:0]                 i_phase;
  logic                       i_ref_bit;
  logic                       o_dec_bit;
  logic                       o_dec_valid;
  logic                       o_lock;
  logic [NB_DLY-1:0]          o_delay;
  logic [NB_CNT-1:0]          o_bit_cnt;
  logic [NB_CNT-1:0]          o_err_cnt;
  modport master (
    output i_os_data, i_valid, i_enb, i_phase, i_ref_bit,
    input  o_dec_bit, o_dec_valid, o_lock, o_delay, o_bit_cnt, o_err_cnt
  );
  modport slave (
    input  i_os_data, i_valid, i_enb, i_phase, i_ref_bit,
    output o_dec_bit, o_dec_valid, o_lock, o_delay, o_bit_cnt, o_err_cnt
  );
endinterface

// File: rtl/ber_checker.sv
// ber_checker: decimate and slice the filter output, align to reference PRBS by latency search, count BER.
module ber_checker #(
  parameter int NB_INPUT  = 8,
  parameter int OV_SAMP   = 4,
  parameter int NB_DLY    = 5,
  parameter int ALIGN_WIN = 128,
  parameter int LOL_THR   = 16,
  parameter int NB_CNT    = 32
) (
  input logic          clk,
  input logic          i_srst,
  ber_checker_if.slave bus
);
  localparam int NH = 2**NB_DLY;
  localparam int NW = $clog2(ALIGN_WIN) + 1;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [NH-1:0]     hist_q, hist_d;
  logic [NW-1:0]     wcnt_q, wcnt_d, werr_q, werr_d, wcnt_n, werr_n;
  logic [NB_DLY-1:0] dly_q, dly_d;
  logic [NB_CNT-1:0] bcnt_q, bcnt_d, ecnt_q, ecnt_d;
  logic              dbit_q, dbit_d, dval_q, dval_d;
  logic              strobe, dec, mism, win_end, lol;
  always_comb begin
    strobe  = bus.i_valid && ph_q == bus.i_phase;
    dec     = bus.i_os_data[NB_INPUT-1];
    // hist_q[0] holds the reference from the previous strobe, so latency d reads hist_q[d-1]
    mism    = dec ^ (dly_q == '0 ? bus.i_ref_bit : hist_q[dly_q - 1'b1]);
    wcnt_n  = wcnt_q + 1'b1;
    werr_n  = werr_q + NW'(mism);
    win_end = wcnt_n == NW'(ALIGN_WIN);
    lol     = state_q == LOCKED && werr_n >= NW'(LOL_THR);
    ph_d    = bus.i_valid ? (ph_q == 2'(OV_SAMP-1) ? 2'd0 : ph_q + 2'd1) : ph_q;
    hist_d  = strobe ? {hist_q[NH-2:0], bus.i_ref_bit} : hist_q;
    dbit_d  = strobe ? dec : dbit_q;
    dval_d  = strobe;
  end
  always_comb begin
    state_d = state_q;
    if (!bus.i_enb)
      state_d = IDLE;
    else if (state_q == IDLE)
      state_d = SEARCH;
    else if (strobe && state_q == SEARCH && win_end && werr_n == '0)
      state_d = LOCKED;
    else if (strobe && lol)
      state_d = SEARCH;
  end
  always_comb begin
    wcnt_d = wcnt_q;
    werr_d = werr_q;
    dly_d  = dly_q;
    bcnt_d = bcnt_q;
    ecnt_d = ecnt_q;
    if (state_q == IDLE) begin
      if (bus.i_enb) begin
        wcnt_d = '0;
        werr_d = '0;
        dly_d  = '0;
        bcnt_d = '0;
        ecnt_d = '0;
      end
    end else if (strobe) begin
      wcnt_d = (win_end || lol) ? '0 : wcnt_n;
      werr_d = (win_end || lol) ? '0 : werr_n;
      dly_d  = (state_q == SEARCH && win_end && werr_n != '0) ? dly_q + 1'b1 : dly_q;
      if (state_q == LOCKED) begin
        bcnt_d = &bcnt_q ? bcnt_q : bcnt_q + 1'b1;
        ecnt_d = (&ecnt_q || !mism) ? ecnt_q : ecnt_q + 1'b1;
      end
    end
  end
  always_comb begin
    bus.o_lock      = state_q == LOCKED;
    bus.o_dec_bit   = dbit_q;
    bus.o_dec_valid = dval_q;
    bus.o_delay     = dly_q;
    bus.o_bit_cnt   = bcnt_q;
    bus.o_err_cnt   = ecnt_q;
  end
  always_ff @(posedge clk or posedge i_srst)
    if (i_srst) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or posedge i_srst)
    if (i_srst) begin
      ph_q   <= '0;
      hist_q <= '0;
      wcnt_q <= '0;
      werr_q <= '0;
      dly_q  <= '0;
      bcnt_q <= '0;
      ecnt_q <= '0;
      dbit_q <= 1'b0;
      dval_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      hist_q <= hist_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
      dly_q  <= dly_d;
      bcnt_q <= bcnt_d;
      ecnt_q <= ecnt_d;
      dbit_q <= dbit_d;
      dval_q <= dval_d;
    end
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: scoreboard bench for decimation, latency search, error counting and loss of lock.
module tb_ber_checker;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail = 0;
  int   tb_ph = 0;
  int   npulse = 0;
  logic tb_strb;
  logic mon_en;
  logic sb[$];
  logic rmem[$];
  logic [8:0] lfsr = 9'h1ff;
  logic signed [7:0] pat [4] = '{8'sd64, 8'sd64, -8'sd64, 8'sd64};
  ber_checker_if #(.NB_INPUT(8), .NB_DLY(5), .NB_CNT(32)) bus ();
  ber_checker dut (.clk(clk), .i_srst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_lock"}, 64'(bus.o_lock), 0);
    check({tag, "_dly"}, 64'(bus.o_delay), 0);
    check({tag, "_bit"}, 64'(bus.o_bit_cnt), 0);
    check({tag, "_err"}, 64'(bus.o_err_cnt), 0);
    check({tag, "_dbit"}, 64'(bus.o_dec_bit), 0);
    check({tag, "_dval"}, 64'(bus.o_dec_valid), 0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      tb_strb = 1'b0;
    end
  endtask
  task automatic samp(input logic signed [7:0] d, input logic r, input logic eb);
    @(negedge clk);
    bus.i_os_data = d;
    bus.i_valid = 1'b1;
    bus.i_ref_bit = r;
    tb_strb = (tb_ph == int'(bus.i_phase));
    if (tb_strb) sb.push_back(eb);
    tb_ph = (tb_ph + 1) % 4;
  endtask
  task automatic sym(input logic flip);
    logic r, b;
    int k;
    r = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    k = rmem.size();
    b = (k >= 7) ? rmem[k-7] : 1'b0;
    rmem.push_back(r);
    b = b ^ flip;
    for (int s = 0; s < 4; s++) samp(b ? -8'sd64 : 8'sd64, r, b);
  endtask
  always @(posedge clk) begin
    logic s;
    s = tb_strb;
    #1;
    if (mon_en) begin
      check("dec_valid", 64'(bus.o_dec_valid), 64'(s));
      if (bus.o_dec_valid) npulse++;
      if (s) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else check("dec_bit", 64'(bus.o_dec_bit), 64'(sb.pop_front()));
      end
    end
  end
  initial begin
    rst = 1'b1;
    mon_en = 1'b0;
    tb_strb = 1'b0;
    bus.i_os_data = '0;
    bus.i_valid = 1'b0;
    bus.i_enb = 1'b0;
    bus.i_phase = 2'd0;
    bus.i_ref_bit = 1'b0;
    repeat (6) @(negedge clk) bus.i_valid = ~bus.i_valid;
    check_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    idle(4);
    check_zero("rel");
    mon_en = 1'b1;
    bus.i_phase = 2'd2;
    for (int i = 0; i < 8; i++)
      for (int s = 0; s < 4; s++) samp(pat[s], 1'b0, s == 2);
    idle(2);
    check("dec_pulses", 64'(npulse), 8);
    bus.i_phase = 2'd0;
    bus.i_enb = 1'b1;
    idle(2);
    repeat (1023) sym(1'b0);
    idle(1);
    check("pre_lock", 64'(bus.o_lock), 0);
    check("pre_dly", 64'(bus.o_delay), 7);
    sym(1'b0);
    idle(1);
    check("lock", 64'(bus.o_lock), 1);
    check("lock_dly", 64'(bus.o_delay), 7);
    check("lock_err", 64'(bus.o_err_cnt), 0);
    check("lock_bit", 64'(bus.o_bit_cnt), 0);
    for (int i = 0; i < 1000; i++) sym(i == 100 || i == 400 || i == 800);
    idle(1);
    check("ec_err", 64'(bus.o_err_cnt), 3);
    check("ec_bit", 64'(bus.o_bit_cnt), 1000);
    check("ec_lock", 64'(bus.o_lock), 1);
    bus.i_enb = 1'b0;
    idle(2);
    check("dis_lock", 64'(bus.o_lock), 0);
    check("dis_err", 64'(bus.o_err_cnt), 3);
    check("dis_bit", 64'(bus.o_bit_cnt), 1000);
    bus.i_enb = 1'b1;
    idle(2);
    check("en_err", 64'(bus.o_err_cnt), 0);
    check("en_bit", 64'(bus.o_bit_cnt), 0);
    check("en_dly", 64'(bus.o_delay), 0);
    repeat (1024) sym(1'b0);
    idle(1);
    check("relock", 64'(bus.o_lock), 1);
    repeat (15) sym(1'b1);
    idle(1);
    check("lol15_lock", 64'(bus.o_lock), 1);
    check("lol15_err", 64'(bus.o_err_cnt), 15);
    sym(1'b1);
    idle(1);
    check("lol_lock", 64'(bus.o_lock), 0);
    check("lol_err", 64'(bus.o_err_cnt), 16);
    check("lol_bit", 64'(bus.o_bit_cnt), 16);
    check("lol_dly", 64'(bus.o_delay), 7);
    repeat (127) sym(1'b0);
    idle(1);
    check("rs_pre", 64'(bus.o_lock), 0);
    sym(1'b0);
    idle(1);
    check("rs_lock", 64'(bus.o_lock), 1);
    check("rs_dly", 64'(bus.o_delay), 7);
    check("rs_err", 64'(bus.o_err_cnt), 16);
    check("rs_bit", 64'(bus.o_bit_cnt), 16);
    bus.i_enb = 1'b0;
    idle(1);
    bus.i_enb = 1'b1;
    idle(2);
    repeat (384) sym(1'b0);
    idle(1);
    check("srch_dly", 64'(bus.o_delay), 3);
    check("srch_lock", 64'(bus.o_lock), 0);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    idle(2);
    rst = 1'b0;
    tb_ph = 0;
    sb.delete();
    rmem.delete();
    mon_en = 1'b1;
    idle(2);
    check("post_dly", 64'(bus.o_delay), 0);
    check("post_lock", 64'(bus.o_lock), 0);
    repeat (128) sym(1'b0);
    idle(1);
    check("post_win_dly", 64'(bus.o_delay), 1);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Receive-side checker downstream of the polyphase raised-cosine TX filter. Takes the filter's oversampled output stream (OV_SAMP samples per symbol) and decimates it with a selectable phase.
- Slices each kept sample to a hard bit and aligns that bit to a reference PRBS bit stream by searching over latency.
- Once aligned, accumulates bit and error counts for BER measurement. Sits at the end of the TX-filter datapath alongside the PRBS generator that feeds the filter.

Parameters:
- NB_INPUT, 8, width of the filter sample (signed, S(8,7)).
- OV_SAMP, 4, oversampling factor; samples per symbol.
- NB_DLY, 5, width of the latency index; the reference history holds 2**NB_DLY bits.
- ALIGN_WIN, 128, symbols compared per candidate latency, and per loss-of-lock window.
- LOL_THR, 16, errors within one window, while locked, that force a re-search.
- NB_CNT, 32, width of the bit and error counters.

Ports:
- clk, in, 1, clock.
- i_srst, in, 1, reset; asynchronous, active-high.
- i_os_data, in, NB_INPUT, signed filter output sample.
- i_valid, in, 1, i_os_data is valid this cycle (one per oversampled sample).
- i_enb, in, 1, checker enable.
- i_phase, in, 2, decimation phase, 0..OV_SAMP-1.
- i_ref_bit, in, 1, reference PRBS bit; sampled on each decimation strobe.
- o_dec_bit, out, 1, sliced decision.
- o_dec_valid, out, 1, one-cycle pulse when o_dec_bit updates.
- o_lock, out, 1, alignment achieved.
- o_delay, out, NB_DLY, current or locked latency candidate.
- o_bit_cnt, out, NB_CNT, symbols compared while locked.
- o_err_cnt, out, NB_CNT, errors counted while locked.

Behaviour:
- Reset (async, i_srst=1): all outputs 0; phase counter 0; reference history 0; window counters 0; FSM in IDLE.
- Phase counter: increments mod OV_SAMP on each i_valid=1 cycle; holds when i_valid=0. Runs regardless of i_enb.
- Strobe: i_valid=1 and phase counter == i_phase. Exactly one strobe per OV_SAMP valid samples. Changing i_phase takes effect on the next valid sample.
- Slicer: decision = i_os_data[NB_INPUT-1]. A negative sample gives bit 1, matching the filter's sign-selects-negated-coefficient mapping. Zero slices to 0.
- Decision output: o_dec_bit and o_dec_valid are registered one clk after the strobe. o_dec_valid is a single-cycle pulse.
- Reference history: a 2**NB_DLY-bit shift register. On each strobe, i_ref_bit shifts into position 0.
- Compare: at strobe k, compare decision b_k against r_(k-d), where d is the current latency candidate and r_k is the i_ref_bit value at strobe k. d=0 compares against the current i_ref_bit. History positions not yet filled since reset read 0.
- FSM states:
  - IDLE: entered while i_enb=0. Counters hold their values; o_lock=0.
  - IDLE -> SEARCH: on i_enb=1. Clears o_bit_cnt, o_err_cnt, the window counters, and d.
  - SEARCH: each strobe increments the window symbol count and adds the mismatch to the window error count. When the window reaches ALIGN_WIN symbols:
    - if window errors == 0: go to LOCKED with d kept; o_lock=1 from the next cycle.
    - otherwise: d = d+1, wrapping from 2**NB_DLY-1 to 0, and restart the window.
  - LOCKED: each strobe increments o_bit_cnt and adds the mismatch to o_err_cnt. A running window of ALIGN_WIN symbols also tracks errors. If window errors reach LOL_THR: return to SEARCH, keep d, clear the window counters, set o_lock=0. o_bit_cnt and o_err_cnt are retained until the next IDLE->SEARCH transition.
  - Any state -> IDLE: on i_enb=0, effective on the next clk.
- Counters saturate at all-ones and never wrap.
- A strobe in the same cycle as a state transition is evaluated in the old state.
- Reset asserted mid-search or mid-lock immediately returns everything to the reset values.

Test Plan:
- Reset: hold i_srst=1 with i_valid toggling -> all outputs 0. Release with i_enb=0 -> o_lock stays 0, counters stay 0.
- Decimation: OV_SAMP=4, i_phase=2, repeating samples {+64, +64, -64, +64}, valid every cycle -> o_dec_bit=1 on every pulse, one pulse per 4 samples, each pulse 1 clk after the third sample.
- Alignment: ref = PRBS9; samples are ±64 encoding that PRBS delayed 7 symbols; i_enb=1 -> o_lock rises after 8*128 strobes, o_delay=7, o_err_cnt=0.
- Error count: after lock, invert 3 isolated decision samples over 1000 symbols -> o_err_cnt=3, o_bit_cnt=1000, o_lock stays 1.
- Loss of lock: after lock, invert 16 decisions within one 128-symbol window -> o_lock falls. Remove the errors -> re-lock at o_delay=7 with o_err_cnt retained at 16.
- Reset mid-search: assert i_srst during the search at d=3 -> immediate zeros. After release with i_enb=1, the search restarts at d=0.
